exec_ctrl: RTL and testbench
============================

// Module: exec_ctrl
// PURPOSE
//  Multi-cycle issue/control stage directly upstream of the 8-bit ALU.
//  - Accepts one 16-bit instruction per valid/ready handshake.
//  - Reads operands from the register file and drives registered alu_a/alu_b/alu_ctrl.
//  - Captures the ALU result and issues a one-cycle register-file write.
// PARAMETERS
//  DATA_W   8   operand/result width; must match ALU width
//  RA_W     3   register address width (8 registers, r0 reads as written, never written)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  instr_valid  in   1       upstream has an instruction on instr
//  instr_ready  out  1       stage can accept; transfer when valid & ready at clk edge
//  instr        in   16      [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LDI)
//  rf_raddr_a   out  RA_W    register file read address A (combinational read)
//  rf_raddr_b   out  RA_W    register file read address B
//  rf_rdata_a   in   DATA_W  read data A, valid same cycle as address
//  rf_rdata_b   in   DATA_W  read data B
//  alu_a        out  DATA_W  ALU operand A (registered)
//  alu_b        out  DATA_W  ALU operand B (registered)
//  alu_ctrl     out  4       ALU operation select (registered)
//  alu_result   in   DATA_W  combinational ALU output
//  rf_we        out  1       register write strobe, one cycle
//  rf_waddr     out  RA_W    write address
//  rf_wdata     out  DATA_W  write data
//  busy         out  1       1 in any state other than IDLE
//  illegal      out  1       one-cycle pulse on an undefined opcode
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, instr_ready=1.
//    All other outputs are 0, including rf_we and illegal; an in-flight instruction is dropped.
//  - States: IDLE -> DECODE -> EXEC -> WB -> IDLE.
//    - IDLE: instr_ready=1. On valid&ready, latch instr and go to DECODE.
//    - DECODE: instr_ready=0. rf_raddr_a=rs1, rf_raddr_b=rs2.
//      - op 0000..0110: latch alu_a=rf_rdata_a, alu_b=rf_rdata_b, alu_ctrl=op; go to EXEC.
//      - op 1000 (LDI): alu_a=imm, alu_b=0, alu_ctrl=0000 (ADD); go to EXEC.
//      - op 1111 (NOP): go to IDLE, no side effects.
//      - any other op: illegal=1 for this cycle only; go to IDLE; no write.
//    - EXEC: ALU inputs stable; latch rf_wdata=alu_result, rf_waddr=rd; go to WB.
//    - WB: rf_we=1 for exactly one cycle unless rd==0 (then rf_we=0); go to IDLE.
//  - Latency: accept at edge N; rf_we high during cycle N+3.
//    Throughput is 1 instruction per 4 cycles; next accept at edge N+4.
//  - instr_valid in non-IDLE states is ignored (ready=0); upstream holds instr stable.
//  - alu_a/alu_b/alu_ctrl hold their last values outside DECODE updates.
//    rf_wdata/rf_waddr hold after WB.
//  - Arithmetic is modulo 2^DATA_W (ALU wraps; no carry kept).
//    Shift amount is the full alu_b value.
//  - rs1==rs2 and rd==rs1 are legal: operands are captured in DECODE, before the write.
// CONFIGURATION
//  EXEC_CTRL_ZERO_FLAG_EN defined:
//  - Adds output port zero_flag (1 bit), reset 0.
//  - Updated at the WB edge to (rf_wdata==0) for ALU ops and LDI, including rd==0.
//  - Unchanged by NOP or illegal instructions.
//  Not defined: port and logic absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 mid-EXEC -> outputs 0 and instr_ready=1 at once; no rf_we after release.
//  2. ADD: r1=0x7F, r2=0x01, instr=0x0288 (add r1<-r1+r2)
//     -> alu_ctrl=0, rf_we in cycle N+3, waddr=1, wdata=0x80.
//  3. SUB wrap: r3=0x00, r4=0x01, op 0001 rd=5 -> wdata=0xFF.
//     With EXEC_CTRL_ZERO_FLAG_EN: zero_flag=0.
//  4. LDI: instr=0x8A5C (rd=5, imm=0x5C) -> alu_a=0x5C, alu_b=0, wdata=0x5C.
//     Then LDI rd=0 imm=0x00 -> rf_we stays 0; zero_flag=1 if enabled.
//  5. Illegal/NOP: op 1010 -> illegal pulse in N+1, no rf_we, ready back at N+2.
//     op 1111 -> no pulse, no rf_we.
//  6. Back-pressure: instr_valid held high for 3 back-to-back instrs -> accepts at N, N+4, N+8.
//     Each write is correct and none is lost or duplicated.

Source files
------------

// File: rtl/exec_ctrl.sv
// Multi-cycle issue/control stage in front of the ALU: IDLE -> DECODE -> EXEC -> WB.
// Optional EXEC_CTRL_ZERO_FLAG_EN adds a zero_flag output updated on each register write-back.
module exec_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [15:0]       i_instr,
    output logic [RA_W-1:0]   o_rf_raddr_a,
    output logic [RA_W-1:0]   o_rf_raddr_b,
    input  logic [DATA_W-1:0] i_rf_rdata_a,
    input  logic [DATA_W-1:0] i_rf_rdata_b,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [3:0]        o_alu_ctrl,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_rf_we,
    output logic [RA_W-1:0]   o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_busy,
    output logic              o_illegal
`ifdef EXEC_CTRL_ZERO_FLAG_EN
    ,
    output logic              o_zero_flag
`endif
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [15:0]         r_instr;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [3:0]          r_alu_ctrl;
    logic [RA_W-1:0]     r_waddr;
    logic [DATA_W-1:0]   r_wdata;

    logic [3:0]          w_op;
    logic [RA_W-1:0]     w_rd;
    logic [RA_W-1:0]     w_rs1;
    logic [RA_W-1:0]     w_rs2;
    logic [DATA_W-1:0]   w_imm;
    logic                w_accept;
    logic                w_op_ld;
    logic                w_wb_ld;
    logic                w_illegal;
    logic [DATA_W-1:0]   w_alu_a_d;
    logic [DATA_W-1:0]   w_alu_b_d;
    logic [3:0]          w_alu_ctrl_d;

    assign w_op  = r_instr[15:12];
    assign w_rd  = RA_W'(r_instr[11:9]);
    assign w_rs1 = RA_W'(r_instr[8:6]);
    assign w_rs2 = RA_W'(r_instr[5:3]);
    assign w_imm = DATA_W'(r_instr[7:0]);

    assign w_accept = (r_state == StIdle) && i_instr_valid;

    always_comb begin
        w_state_d    = r_state;
        w_op_ld      = 1'b0;
        w_wb_ld      = 1'b0;
        w_illegal    = 1'b0;
        w_alu_a_d    = r_alu_a;
        w_alu_b_d    = r_alu_b;
        w_alu_ctrl_d = r_alu_ctrl;
        unique case (r_state)
            StIdle: begin
                if (i_instr_valid) w_state_d = StDecode;
            end
            StDecode: begin
                if (w_op inside {[4'd0:4'd6]}) begin
                    w_op_ld      = 1'b1;
                    w_alu_a_d    = i_rf_rdata_a;
                    w_alu_b_d    = i_rf_rdata_b;
                    w_alu_ctrl_d = w_op;
                    w_state_d    = StExec;
                end else if (w_op == 4'b1000) begin
                    // LDI goes through the ALU as imm + 0
                    w_op_ld      = 1'b1;
                    w_alu_a_d    = w_imm;
                    w_alu_b_d    = '0;
                    w_alu_ctrl_d = 4'b0000;
                    w_state_d    = StExec;
                end else if (w_op == 4'b1111) begin
                    w_state_d = StIdle;
                end else begin
                    w_illegal = 1'b1;
                    w_state_d = StIdle;
                end
            end
            StExec: begin
                w_wb_ld   = 1'b1;
                w_state_d = StWb;
            end
            StWb: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_instr    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) r_instr <= i_instr;
            if (w_op_ld) begin
                r_alu_a    <= w_alu_a_d;
                r_alu_b    <= w_alu_b_d;
                r_alu_ctrl <= w_alu_ctrl_d;
            end
            if (w_wb_ld) begin
                r_waddr <= w_rd;
                r_wdata <= i_alu_result;
            end
        end
    end

`ifdef EXEC_CTRL_ZERO_FLAG_EN
    logic r_zero_flag;

    // Tracks every write-back, including rd == 0 where the strobe is suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_flag <= 1'b0;
        end else if (r_state == StWb) begin
            r_zero_flag <= (r_wdata == '0);
        end
    end

    assign o_zero_flag = r_zero_flag;
`endif

    assign o_instr_ready = (r_state == StIdle);
    assign o_busy        = (r_state != StIdle);
    assign o_illegal     = w_illegal;
    assign o_rf_raddr_a  = w_rs1;
    assign o_rf_raddr_b  = w_rs2;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_ctrl    = r_alu_ctrl;
    assign o_rf_we       = (r_state == StWb) && (r_waddr != '0);
    assign o_rf_waddr    = r_waddr;
    assign o_rf_wdata    = r_wdata;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios plus random instructions
// checked against an architectural register-file model.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  raddr_a, raddr_b, waddr;
    logic [7:0]  rdata_a, rdata_b, alu_a, alu_b, alu_result, wdata;
    logic [3:0]  alu_ctrl;
    logic        rf_we, busy, illegal;
`ifdef EXEC_CTRL_ZERO_FLAG_EN
    logic        zero_flag;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    logic [7:0] rf [8];
    logic [7:0] exp_rf [8];
    logic [7:0] exp_a, exp_b, exp_wdata;
    logic [3:0] exp_ctrl;
    logic [2:0] exp_waddr;
    logic       exp_zero;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment register file: combinational read, r0 never written
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (rf_we && waddr != 3'd0) begin
            rf[waddr] <= wdata;
        end
    end
    assign rdata_a = rf[raddr_a];
    assign rdata_b = rf[raddr_b];

    function automatic logic [7:0] alu_fn(input logic [3:0] c, input logic [7:0] a,
                                          input logic [7:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b;
            4'd6:    return a >> b;
            default: return 8'h00;
        endcase
    endfunction
    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    exec_ctrl #(.DATA_W(8), .RA_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_instr       (instr),
        .o_rf_raddr_a  (raddr_a),
        .o_rf_raddr_b  (raddr_b),
        .i_rf_rdata_a  (rdata_a),
        .i_rf_rdata_b  (rdata_b),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_ctrl    (alu_ctrl),
        .i_alu_result  (alu_result),
        .o_rf_we       (rf_we),
        .o_rf_waddr    (waddr),
        .o_rf_wdata    (wdata),
        .o_busy        (busy),
        .o_illegal     (illegal)
`ifdef EXEC_CTRL_ZERO_FLAG_EN
        ,
        .o_zero_flag   (zero_flag)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] mk_r(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'h8, rd, 1'b0, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_rf[i] = 8'h00;
        exp_a = 8'h00; exp_b = 8'h00; exp_ctrl = 4'h0;
        exp_wdata = 8'h00; exp_waddr = 3'd0; exp_zero = 1'b0;
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_alu_a"}, alu_a, exp_a);
        chk({tag, "_alu_b"}, alu_b, exp_b);
        chk({tag, "_alu_ctrl"}, alu_ctrl, exp_ctrl);
        chk({tag, "_waddr"}, waddr, exp_waddr);
        chk({tag, "_wdata"}, wdata, exp_wdata);
`ifdef EXEC_CTRL_ZERO_FLAG_EN
        chk({tag, "_zero"}, zero_flag, exp_zero);
`endif
    endtask

    // Called at a negedge while the DUT should be idle; returns at the negedge
    // of the first idle cycle after the instruction retires.
    task automatic issue(input logic [15:0] ins, input bit hold);
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] res;
        bit         legal;
        int         n;
        op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
        legal = (op <= 4'd6) || (op == 4'd8);
        n = 0;
        while (instr_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", instr_ready, 1);
        chk("idle_busy", busy, 0);
        instr_valid = 1'b1;
        instr = ins;
        @(negedge clk);
        last_acc = cyc;
        if (!hold) instr_valid = 1'b0;
        chk("dec_ready", instr_ready, 0);
        chk("dec_busy", busy, 1);
        chk("dec_illegal", illegal, (legal || op == 4'd15) ? 0 : 1);
        chk("dec_raddr_a", raddr_a, rs1);
        chk("dec_raddr_b", raddr_b, rs2);
        chk("dec_we", rf_we, 0);
        if (legal) begin
            if (op == 4'd8) begin
                exp_a = ins[7:0]; exp_b = 8'h00; exp_ctrl = 4'd0;
            end else begin
                exp_a = exp_rf[rs1]; exp_b = exp_rf[rs2]; exp_ctrl = op;
            end
            res = alu_fn(exp_ctrl, exp_a, exp_b);
            @(negedge clk);
            chk("exe_alu_a", alu_a, exp_a);
            chk("exe_alu_b", alu_b, exp_b);
            chk("exe_alu_ctrl", alu_ctrl, exp_ctrl);
            chk("exe_we", rf_we, 0);
            @(negedge clk);
            chk("wb_we", rf_we, (rd != 3'd0) ? 1 : 0);
            chk("wb_waddr", waddr, rd);
            chk("wb_wdata", wdata, res);
            chk("wb_illegal", illegal, 0);
            if (rd != 3'd0) exp_rf[rd] = res;
            exp_waddr = rd;
            exp_wdata = res;
            exp_zero = (res == 8'h00);
        end
        @(negedge clk);
        chk("ret_ready", instr_ready, 1);
        chk("ret_we", rf_we, 0);
        chk("ret_illegal", illegal, 0);
        check_held("ret");
    endtask

    initial begin
        int a0, a1, a2;
        logic [15:0] ri;
        int sel;
        instr_valid = 1'b0;
        instr = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_illegal", illegal, 0);
        check_held("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with wrap into the sign bit
        issue(mk_ldi(3'd1, 8'h7F), 1'b0);
        issue(mk_ldi(3'd2, 8'h01), 1'b0);
        issue(16'h0288, 1'b0);
        chk("add_r1", exp_rf[1], 8'h80);

        // SUB wrapping below zero
        issue(mk_ldi(3'd3, 8'h00), 1'b0);
        issue(mk_ldi(3'd4, 8'h01), 1'b0);
        issue(mk_r(4'd1, 3'd5, 3'd3, 3'd4), 1'b0);
        chk("sub_wdata", wdata, 8'hFF);

        // LDI, then LDI to r0 (no strobe, zero result)
        issue(16'h8A5C, 1'b0);
        chk("ldi_wdata", wdata, 8'h5C);
        issue(16'h8000, 1'b0);

        // Illegal and NOP leave datapath and flags untouched
        issue(16'hA000, 1'b0);
        issue(16'h7123, 1'b0);
        issue(16'hF000, 1'b0);

        // rd == rs1 == rs2 and shifts by large amounts
        issue(mk_r(4'd0, 3'd1, 3'd1, 3'd1), 1'b0);
        issue(mk_ldi(3'd6, 8'h09), 1'b0);
        issue(mk_r(4'd5, 3'd7, 3'd2, 3'd6), 1'b0);

        // Back-pressure: valid held high across three instructions
        issue(mk_r(4'd4, 3'd2, 3'd1, 3'd5), 1'b1);
        a0 = last_acc;
        issue(mk_r(4'd2, 3'd3, 3'd2, 3'd5), 1'b1);
        a1 = last_acc;
        issue(mk_r(4'd3, 3'd4, 3'd3, 3'd1), 1'b1);
        a2 = last_acc;
        instr_valid = 1'b0;
        chk("bp_gap1", a1 - a0, 4);
        chk("bp_gap2", a2 - a1, 4);

        // Reset in the middle of EXEC drops the instruction
        instr_valid = 1'b1;
        instr = mk_r(4'd0, 3'd6, 3'd1, 3'd2);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_ready", instr_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_illegal", illegal, 0);
        chk("mid_rst_raddr_a", raddr_a, 0);
        check_held("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_we", rf_we, 0);
        end

        // Random instruction mix
        for (int i = 0; i < 40; i++) begin
            ri = 16'($urandom);
            sel = int'($urandom_range(0, 11));
            if (sel <= 6) ri[15:12] = 4'(sel);
            else if (sel <= 8) ri[15:12] = 4'd8;
            else if (sel == 9) ri[15:12] = 4'd15;
            else if (sel == 10) ri[15:12] = 4'd7;
            else ri[15:12] = 4'($urandom_range(9, 14));
            issue(ri, 1'($urandom_range(0, 1)));
            instr_valid = 1'b0;
        end
        for (int i = 1; i < 8; i++) begin
            chk("final_rf", rf[i], exp_rf[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
